// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: 256 x 128-bit lines, tags/valid/dirty held here.
// Define DCACHE_STAT_EN to build the hit/miss counters; otherwise stat_hit/stat_miss are tied to 0.
module dcache_ctrl (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cpu_req_valid,
  output logic         cpu_req_ready,
  input  logic         cpu_req_wr,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_wdata,
  input  logic [3:0]   cpu_req_wstrb,
  output logic         cpu_resp_valid,
  input  logic         cpu_resp_ready,
  output logic [31:0]  cpu_resp_rdata,
  output logic         da_we,
  output logic [7:0]   da_rindex,
  output logic [7:0]   da_windex,
  output logic [127:0] da_wdata,
  input  logic [127:0] da_rdata,
  output logic         mem_req,
  output logic         mem_wr,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  stat_hit,
  output logic [31:0]  stat_miss
);

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StRefill, StResp} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [31:2]  r_addr;
  logic         r_wr;
  logic [31:0]  r_wdata;
  logic [3:0]   r_wstrb;
  logic [31:0]  r_rdata;
  logic [127:0] r_wb_data;

  logic [19:0]  r_tag [256];
  logic [255:0] r_valid;
  logic [255:0] r_dirty;

  logic [19:0]  w_tag;
  logic [7:0]   w_index;
  logic [1:0]   w_word;
  logic         w_hit;
  logic         w_victim_dirty;
  logic         w_accept;
  logic         w_fill_done;
  logic         w_unused_addr;

  assign w_tag          = r_addr[31:12];
  assign w_index        = r_addr[11:4];
  assign w_word         = r_addr[3:2];
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_accept       = cpu_req_valid && (r_state == StIdle);
  assign w_fill_done    = (r_state == StRefill) && mem_ready;
  assign w_unused_addr  = ^cpu_req_addr[1:0];

  assign da_rindex      = w_index;
  assign da_windex      = w_index;
  assign cpu_resp_rdata = r_rdata;

  function automatic logic [127:0] f_merge(input logic [127:0] line, input logic [1:0] word,
                                           input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[{word, b[1:0], 3'b000} +: 8] = wdata[{b[1:0], 3'b000} +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] f_word(input logic [127:0] line, input logic [1:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (cpu_req_valid) w_state_nxt = StLookup;
      StLookup: begin
        if (w_hit)               w_state_nxt = StResp;
        else if (w_victim_dirty) w_state_nxt = StWb;
        else                     w_state_nxt = StRefill;
      end
      StWb:     if (mem_ready) w_state_nxt = StRefill;
      StRefill: if (mem_ready) w_state_nxt = StResp;
      StResp:   if (cpu_resp_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    da_we          = 1'b0;
    da_wdata       = '0;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (r_state)
      StIdle:   cpu_req_ready = 1'b1;
      StLookup: begin
        if (w_hit && r_wr) begin
          da_we    = 1'b1;
          da_wdata = f_merge(da_rdata, w_word, r_wdata, r_wstrb);
        end
      end
      StWb: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {r_tag[w_index], w_index, 4'h0};
        mem_wdata = r_wb_data;
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_index, 4'h0};
        if (mem_ready) begin
          da_we    = 1'b1;
          da_wdata = r_wr ? f_merge(mem_rdata, w_word, r_wdata, r_wstrb) : mem_rdata;
        end
      end
      StResp:   cpu_resp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Victim line is captured on leaving LOOKUP so WB data stays stable whatever the array does.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_req_addr[31:2];
        r_wr    <= cpu_req_wr;
        r_wdata <= cpu_req_wdata;
        r_wstrb <= cpu_req_wstrb;
      end
      if (r_state == StLookup) begin
        if (w_hit)               r_rdata   <= r_wr ? 32'h0 : f_word(da_rdata, w_word);
        else if (w_victim_dirty) r_wb_data <= da_rdata;
      end
      if (w_fill_done) r_rdata <= r_wr ? 32'h0 : f_word(mem_rdata, w_word);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if ((r_state == StLookup) && w_hit && r_wr) begin
      r_dirty[w_index] <= 1'b1;
    end else if (w_fill_done) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= r_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) r_tag[w_index] <= w_tag;
  end

`ifdef DCACHE_STAT_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else if (r_state == StLookup) begin
      if (w_hit) r_stat_hit  <= r_stat_hit + 32'd1;
      else       r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign stat_hit  = r_stat_hit;
  assign stat_miss = r_stat_miss;
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl; models the external data array and memory responses.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_ready;
  logic         cpu_req_wr = 1'b0;
  logic [31:0]  cpu_req_addr = '0;
  logic [31:0]  cpu_req_wdata = '0;
  logic [3:0]   cpu_req_wstrb = '0;
  logic         cpu_resp_valid;
  logic         cpu_resp_ready = 1'b0;
  logic [31:0]  cpu_resp_rdata;
  logic         da_we;
  logic [7:0]   da_rindex;
  logic [7:0]   da_windex;
  logic [127:0] da_wdata;
  logic [127:0] da_rdata;
  logic         mem_req;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [31:0]  stat_hit;
  logic [31:0]  stat_miss;

  logic [127:0] da_mem [256];
  int we_cnt = 0;
  int checks = 0;
  int errors = 0;

`ifdef DCACHE_STAT_EN
  localparam bit StatEn = 1'b1;
`else
  localparam bit StatEn = 1'b0;
`endif

  localparam logic [127:0] L1  = 128'h11112222_33334444_DDDDCCCC_BBBBAAAA;
  localparam logic [127:0] L1M = 128'h11112222_33333344_DDDDCCCC_BBBBAAAA;
  localparam logic [127:0] L2  = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [127:0] L3  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] L4  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L4M = 128'h44444444_33333333_AB222222_11111111;

  dcache_ctrl u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_wr     (cpu_req_wr),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_wstrb  (cpu_req_wstrb),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_ready (cpu_resp_ready),
    .cpu_resp_rdata (cpu_resp_rdata),
    .da_we          (da_we),
    .da_rindex      (da_rindex),
    .da_windex      (da_windex),
    .da_wdata       (da_wdata),
    .da_rdata       (da_rdata),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .stat_hit       (stat_hit),
    .stat_miss      (stat_miss)
  );

  always #5 clk = ~clk;

  assign da_rdata = da_mem[da_rindex];

  always @(posedge clk) begin
    if (da_we) begin
      da_mem[da_windex] <= da_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_stat(input int n);
    return StatEn ? 32'(n) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns #1 after the accepting edge (controller in LOOKUP).
  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] wstrb);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_wr    = wr;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = wstrb;
    step();
    cpu_req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    cpu_resp_ready = 1'b1;
    step();
    cpu_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || cpu_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_cpu got rdy=%b vld=%b rdata=%h want 1 0 0",
               cpu_req_ready, cpu_resp_valid, cpu_resp_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_mem got req=%b wr=%b addr=%h wdata=%h want zeros",
               mem_req, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if (da_we !== 1'b0 || da_wdata !== 128'h0 || stat_hit !== 32'h0 || stat_miss !== 32'h0) begin
      errors++;
      $display("FAIL reset_da_stat got we=%b wdata=%h hit=%h miss=%h want zeros",
               da_we, da_wdata, stat_hit, stat_miss);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b want 1", cpu_req_ready);
    end
  endtask

  task automatic test_load_miss();
    send(32'h0000_1004, 1'b0, 32'h0, 4'h0);
    checks++;
    if (mem_req !== 1'b0 || cpu_resp_valid !== 1'b0 || da_rindex !== 8'h00) begin
      errors++;
      $display("FAIL miss_lookup got req=%b vld=%b ridx=%h want 0 0 00",
               mem_req, cpu_resp_valid, da_rindex);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL miss_refill_req got req=%b wr=%b addr=%h want 1 0 00001000",
               mem_req, mem_wr, mem_addr);
    end
    mem_rdata = L1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (da_we !== 1'b1 || da_windex !== 8'h00 || da_wdata !== L1) begin
      errors++;
      $display("FAIL miss_fill_write got we=%b widx=%h wdata=%h want 1 00 %h",
               da_we, da_windex, da_wdata, L1);
    end
    step();
    mem_ready = 1'b0;
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hDDDD_CCCC || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_resp got vld=%b rdata=%h req=%b want 1 ddddcccc 0",
               cpu_resp_valid, cpu_resp_rdata, mem_req);
    end
    checks++;
    if (stat_miss !== exp_stat(1) || stat_hit !== exp_stat(0)) begin
      errors++;
      $display("FAIL miss_stats got hit=%0d miss=%0d want %0d %0d",
               stat_hit, stat_miss, exp_stat(0), exp_stat(1));
    end
    finish_resp();
    checks++;
    if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_back_idle got rdy=%b vld=%b want 1 0", cpu_req_ready, cpu_resp_valid);
    end
  endtask

  task automatic test_load_hit();
    int w0;
    w0 = we_cnt;
    send(32'h0000_1004, 1'b0, 32'h0, 4'h0);
    checks++;
    if (cpu_resp_valid !== 1'b0 || mem_req !== 1'b0 || da_we !== 1'b0) begin
      errors++;
      $display("FAIL hit_lookup got vld=%b req=%b we=%b want 0 0 0",
               cpu_resp_valid, mem_req, da_we);
    end
    step();
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hDDDD_CCCC || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_resp got vld=%b rdata=%h req=%b want 1 ddddcccc 0",
               cpu_resp_valid, cpu_resp_rdata, mem_req);
    end
    checks++;
    if (stat_hit !== exp_stat(1) || stat_miss !== exp_stat(1)) begin
      errors++;
      $display("FAIL hit_stats got hit=%0d miss=%0d want %0d %0d",
               stat_hit, stat_miss, exp_stat(1), exp_stat(1));
    end
    finish_resp();
    checks++;
    if (we_cnt !== w0) begin
      errors++;
      $display("FAIL hit_no_write got we_count=%0d want %0d", we_cnt, w0);
    end
  endtask

  task automatic test_store_hit();
    int w0;
    w0 = we_cnt;
    send(32'h0000_1008, 1'b1, 32'h1122_3344, 4'b0011);
    checks++;
    if (da_we !== 1'b1 || da_windex !== 8'h00 || da_wdata !== L1M) begin
      errors++;
      $display("FAIL store_hit_write got we=%b widx=%h wdata=%h want 1 00 %h",
               da_we, da_windex, da_wdata, L1M);
    end
    step();
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0 || da_we !== 1'b0) begin
      errors++;
      $display("FAIL store_hit_resp got vld=%b rdata=%h we=%b want 1 0 0",
               cpu_resp_valid, cpu_resp_rdata, da_we);
    end
    checks++;
    if (stat_hit !== exp_stat(2)) begin
      errors++;
      $display("FAIL store_hit_stat got hit=%0d want %0d", stat_hit, exp_stat(2));
    end
    finish_resp();
    checks++;
    if (we_cnt !== w0 + 1 || da_mem[0] !== L1M) begin
      errors++;
      $display("FAIL store_hit_array got we_count=%0d line=%h want %0d %h",
               we_cnt, da_mem[0], w0 + 1, L1M);
    end
  endtask

  task automatic test_wb_refill();
    send(32'h0002_1000, 1'b0, 32'h0, 4'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h0000_1000
          || mem_wdata !== L1M) begin
        errors++;
        $display("FAIL wb_hold[%0d] got req=%b wr=%b addr=%h wdata=%h want 1 1 00001000 %h",
                 i, mem_req, mem_wr, mem_addr, mem_wdata, L1M);
      end
      if (i < 5) step();
    end
    mem_rdata = 128'hDEAD;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (da_we !== 1'b0) begin
      errors++;
      $display("FAIL wb_ack_no_write got we=%b want 0", da_we);
    end
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0002_1000) begin
        errors++;
        $display("FAIL refill_hold[%0d] got req=%b wr=%b addr=%h want 1 0 00021000",
                 i, mem_req, mem_wr, mem_addr);
      end
      if (i < 5) step();
    end
    mem_rdata = L2;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (da_we !== 1'b1 || da_wdata !== L2) begin
      errors++;
      $display("FAIL refill_write got we=%b wdata=%h want 1 %h", da_we, da_wdata, L2);
    end
    step();
    mem_ready = 1'b0;
    checks++;
    if (stat_miss !== exp_stat(2) || stat_hit !== exp_stat(2)) begin
      errors++;
      $display("FAIL wb_stats got hit=%0d miss=%0d want %0d %0d",
               stat_hit, stat_miss, exp_stat(2), exp_stat(2));
    end
    // Response stalled for four cycles while a new request is pending.
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_1004;
    cpu_req_wr    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hD3D3_D3D3 || cpu_req_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL resp_stall[%0d] got vld=%b rdata=%h rdy=%b want 1 d3d3d3d3 0",
                 i, cpu_resp_valid, cpu_resp_rdata, cpu_req_ready);
      end
      step();
    end
    cpu_req_valid = 1'b0;
    finish_resp();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if (cpu_req_ready !== 1'b1 || mem_req !== 1'b0 || da_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_ready got rdy=%b req=%b we=%b want 1 0 0",
               cpu_req_ready, mem_req, da_we);
    end
  endtask

  task automatic test_reset_mid_refill();
    int w0;
    send(32'h0000_1004, 1'b0, 32'h0, 4'h0);
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL pre_reset_refill got req=%b addr=%h want 1 00001000", mem_req, mem_addr);
    end
    w0 = we_cnt;
    mem_rdata = L1;
    #2;
    resetn    = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || da_we !== 1'b0 || cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got req=%b addr=%h we=%b rdy=%b want 0 0 0 1",
               mem_req, mem_addr, da_we, cpu_req_ready);
    end
    step();
    mem_ready = 1'b0;
    resetn    = 1'b1;
    step();
    checks++;
    if (we_cnt !== w0 || da_mem[0] !== L2) begin
      errors++;
      $display("FAIL reset_no_write got we_count=%0d line=%h want %0d %h",
               we_cnt, da_mem[0], w0, L2);
    end
    send(32'h0002_1000, 1'b0, 32'h0, 4'h0);
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0002_1000) begin
      errors++;
      $display("FAIL post_reset_miss got req=%b wr=%b addr=%h want 1 0 00021000",
               mem_req, mem_wr, mem_addr);
    end
    mem_rdata = L3;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h7654_3210) begin
      errors++;
      $display("FAIL post_reset_resp got vld=%b rdata=%h want 1 76543210",
               cpu_resp_valid, cpu_resp_rdata);
    end
    checks++;
    if (stat_miss !== exp_stat(1) || stat_hit !== exp_stat(0)) begin
      errors++;
      $display("FAIL post_reset_stats got hit=%0d miss=%0d want %0d %0d",
               stat_hit, stat_miss, exp_stat(0), exp_stat(1));
    end
    finish_resp();
  endtask

  task automatic test_store_miss();
    send(32'h0000_2014, 1'b1, 32'hAB00_0000, 4'b1000);
    checks++;
    if (da_we !== 1'b0) begin
      errors++;
      $display("FAIL store_miss_lookup got we=%b want 0", da_we);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_2010) begin
      errors++;
      $display("FAIL store_miss_refill got req=%b wr=%b addr=%h want 1 0 00002010",
               mem_req, mem_wr, mem_addr);
    end
    mem_rdata = L4;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (da_we !== 1'b1 || da_windex !== 8'h01 || da_wdata !== L4M) begin
      errors++;
      $display("FAIL store_miss_merge got we=%b widx=%h wdata=%h want 1 01 %h",
               da_we, da_windex, da_wdata, L4M);
    end
    step();
    mem_ready = 1'b0;
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_miss_resp got vld=%b rdata=%h want 1 0", cpu_resp_valid, cpu_resp_rdata);
    end
    finish_resp();
    send(32'h0000_2014, 1'b0, 32'h0, 4'h0);
    step();
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hAB22_2222) begin
      errors++;
      $display("FAIL reload_hit got vld=%b rdata=%h want 1 ab222222", cpu_resp_valid, cpu_resp_rdata);
    end
    checks++;
    if (stat_hit !== exp_stat(1) || stat_miss !== exp_stat(2)) begin
      errors++;
      $display("FAIL final_stats got hit=%0d miss=%0d want %0d %0d",
               stat_hit, stat_miss, exp_stat(1), exp_stat(2));
    end
    finish_resp();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) da_mem[i] = '0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_wb_refill();
    test_reset_mid_refill();
    test_store_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
